muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV-style multiply/divide unit: shift-add multiply, restoring divide, sign fix-up in FINISH.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
//
// state  | meaning
// IDLE   | waiting for start; result held
// CALC   | one radix-2 multiply or divide step per cycle
// FINISH | sign correction and high/low selection, done pulse follows
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d;

    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN:0]       mul_sum, rem_sh, rem_diff;
    logic [2*XLEN-1:0]   mul_next, div_next, prod;
    logic [XLEN-1:0]     quot, rem, fin_val;

    // acc holds {high, low}: multiplier shifts out of low, quotient bits shift into low
    always_comb begin
        a_sgn    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_sgn    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = a_sgn && a[XLEN-1];
        b_neg    = b_sgn && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = op[2] && (b == '0);
        div_ovf  = (op == 3'b100 || op == 3'b110) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);

        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (!rem_diff[XLEN])
            div_next = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        prod = neg_q ? -acc_q : acc_q;
        quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fin_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_val = quot;
            default:                fin_val = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    op_d  = op;
                    cnt_d = '0;
                    neg_d = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);
                    // special cases preload acc so FINISH selects the right half unmodified
                    if (div_zero) begin
                        acc_d   = {a, {XLEN{1'b1}}};
                        neg_d   = 1'b0;
                        state_d = FINISH;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, a};
                        neg_d   = 1'b0;
                        state_d = FINISH;
                    end else if (op[2]) begin
                        acc_d   = {{XLEN{1'b0}}, a_mag};
                        opnd_d  = b_mag;
                        state_d = CALC;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        state_d = FINISH;
`else
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        opnd_d  = a_mag;
                        state_d = CALC;
`endif
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1))
                        state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (!kill) begin
                    result_d = fin_val;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result and done cycle, monitor checks on done.
module tb_muldiv_unit;
    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LMUL = 1;
`else
    localparam int LMUL = XLEN + 1;
`endif
    localparam int LDIV = XLEN + 1;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic            clk, reset, start, kill, busy, done;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b, result;
    int              cyc = 0, n_cmp = 0, n_bad = 0, e0;

    typedef struct {
        logic [XLEN-1:0] res;
        int              at;
        string           name;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, result, mon_e.res);
                check({mon_e.name, "_done_cycle"}, cyc, mon_e.at);
                check({mon_e.name, "_busy_at_done"}, busy, 0);
            end
        end
    end

    // called at a negedge with busy=0; returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input logic [XLEN-1:0] exp, input int lat, input string name, input bit push);
        exp_t e;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        e.res = exp; e.at = cyc + lat; e.name = name;
        if (push) sb.push_back(e);
        check({name, "_busy_after_accept"}, busy, 1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && !done && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_reached_idle"}, ok, 1);
    endtask

    task automatic run(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] exp, input int lat, input string name);
        issue(o, x, y, exp, lat, name, 1'b1);
        wait_idle(name);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LMUL, "mul_7_m3");
        run(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LMUL, "mulhu_max");
        run(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LMUL, "mulh_m1_m1");
        run(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LMUL, "mulhsu_m1_2");
        run(MULHSU, 32'd2,        32'hFFFFFFFF, 32'h00000001, LMUL, "mulhsu_2_big");
        run(MUL,    32'h12345678, 32'h10,       32'h23456780, LMUL, "mul_shift");
        run(MULHU,  32'h80000000, 32'd4,        32'h00000002, LMUL, "mulhu_2p33");
        run(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LDIV, "div_m7_2");
        run(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LDIV, "rem_m7_2");
        run(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LDIV, "div_7_m2");
        run(REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, LDIV, "rem_7_m2");
        run(DIVU,   32'd100,      32'd7,        32'd14,       LDIV, "divu_100_7");
        run(REMU,   32'd100,      32'd7,        32'd2,        LDIV, "remu_100_7");
        run(DIVU,   32'd13,       32'd0,        32'hFFFFFFFF, 1,    "divu_by0");
        run(REMU,   32'd13,       32'd0,        32'd13,       1,    "remu_by0");
        run(DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1,    "div_m5_by0");
        run(REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,    "rem_m5_by0");
        run(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,    "div_ovf");
        run(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,    "rem_ovf");

        // start held through FINISH and the done cycle: accepted only after done
        issue(DIVU, 32'd50, 32'd5, 32'd10, LDIV, "b2b_first", 1'b1);
        e0 = cyc;
        while (cyc < e0 + XLEN) @(negedge clk);
        begin
            exp_t e;
            e.res = 32'd11; e.at = e0 + XLEN + 2 + LDIV; e.name = "b2b_second";
            sb.push_back(e);
        end
        op = DIVU; a = 32'd99; b = 32'd9; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_busy", busy, 1);
        wait_idle("b2b");

        // start while busy is ignored
        issue(DIVU, 32'd1000, 32'd3, 32'd333, LDIV, "busy_div", 1'b1);
        e0 = cyc;
        while (cyc < e0 + 4) @(negedge clk);
        op = MUL; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");

        // kill in CALC
        issue(DIV, 32'd1000, 32'd7, 32'd0, LDIV, "kill_calc", 1'b0);
        e0 = cyc;
        while (cyc < e0 + 9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_calc_busy", busy, 0);
        repeat (40) @(negedge clk);
        check("kill_calc_result_held", result, 333);

        // kill in FINISH
        issue(DIVU, 32'd77, 32'd7, 32'd0, LDIV, "kill_finish", 1'b0);
        e0 = cyc;
        while (cyc < e0 + XLEN) @(negedge clk);
        check("kill_finish_busy_before", busy, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_finish_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("kill_finish_result_held", result, 333);

        // kill and start together in IDLE
        op = DIVU; a = 32'd9; b = 32'd0; kill = 1'b1; start = 1'b1;
        @(negedge clk);
        kill = 1'b0; start = 1'b0;
        check("kill_start_idle_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("kill_start_idle_result", result, 333);

        // asynchronous reset mid-divide
        issue(DIV, 32'd1000, 32'd7, 32'd0, LDIV, "rst_div", 1'b0);
        e0 = cyc;
        while (cyc < e0 + 11) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(DIVU, 32'd100, 32'd7, 32'd14, LDIV, "post_rst_divu");

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
